// File: rtl/envio_tela_serial.sv
// Sends a captured screen code plus a 16-bit word as a 5-byte UART 8N1 frame: tela, dados hi, dados lo, xor checksum, terminator.
// Line falls one cycle after the accepting edge; fim pulses 50*CICLOS_POR_BIT+1 cycles later. Requests arriving while busy are dropped.
module envio_tela_serial #(
    parameter int         CICLOS_POR_BIT = 434,
    parameter logic [7:0] TERMINADOR     = 8'h0A
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        envia_dados,
    input  logic [7:0]  tela_renderizada,
    input  logic [15:0] dados,
    output logic        saida_serial,
    output logic        fim_envia_dados,
    output logic        ocupado,
    output logic [2:0]  db_estado
);
    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        START  = 3'd1,
        DADOS  = 3'd2,
        STOP   = 3'd3,
        FIM    = 3'd4
    } estado_t;

    localparam logic [15:0] ULTIMO_CICLO = 16'(CICLOS_POR_BIT - 1);

    estado_t     estado_q, estado_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  byte_q, byte_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tela_q, tela_d;
    logic [7:0]  alto_q, alto_d;
    logic [7:0]  baixo_q, baixo_d;
    logic [7:0]  chk_q, chk_d;
    logic        saida_q, saida_d;
    logic        fim_q, fim_d;
    logic        ocupado_q, ocupado_d;
    logic [7:0]  byte_atual;
    logic        fim_bit;

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        tela_d     = tela_q;
        alto_d     = alto_q;
        baixo_d    = baixo_q;
        chk_d      = chk_q;
        byte_atual = TERMINADOR;
        saida_d    = 1'b1;
        fim_bit    = (cnt_q == ULTIMO_CICLO);

        case (estado_q)
            OCIOSO: begin
                if (envia_dados) begin
                    tela_d   = tela_renderizada;
                    alto_d   = dados[15:8];
                    baixo_d  = dados[7:0];
                    chk_d    = tela_renderizada ^ dados[15:8] ^ dados[7:0];
                    byte_d   = 3'd0;
                    cnt_d    = 16'd0;
                    estado_d = START;
                end
            end
            START: begin
                if (fim_bit) begin
                    cnt_d    = 16'd0;
                    bit_d    = 3'd0;
                    estado_d = DADOS;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DADOS: begin
                if (fim_bit) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        estado_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (fim_bit) begin
                    cnt_d = 16'd0;
                    if (byte_q < 3'd4) begin
                        byte_d   = byte_q + 3'd1;
                        estado_d = START;
                    end else begin
                        estado_d = FIM;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        // Outputs are registered from the next state so the line moves on the same edge as the FSM.
        case (byte_d)
            3'd0:    byte_atual = tela_q;
            3'd1:    byte_atual = alto_q;
            3'd2:    byte_atual = baixo_q;
            3'd3:    byte_atual = chk_q;
            default: byte_atual = TERMINADOR;
        endcase

        case (estado_d)
            START:   saida_d = 1'b0;
            DADOS:   saida_d = byte_atual[bit_d];
            default: saida_d = 1'b1;
        endcase

        fim_d     = (estado_d == FIM);
        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            cnt_q     <= 16'd0;
            byte_q    <= 3'd0;
            bit_q     <= 3'd0;
            tela_q    <= 8'd0;
            alto_q    <= 8'd0;
            baixo_q   <= 8'd0;
            chk_q     <= 8'd0;
            saida_q   <= 1'b1;
            fim_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            tela_q    <= tela_d;
            alto_q    <= alto_d;
            baixo_q   <= baixo_d;
            chk_q     <= chk_d;
            saida_q   <= saida_d;
            fim_q     <= fim_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign saida_serial    = saida_q;
    assign fim_envia_dados = fim_q;
    assign ocupado         = ocupado_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_envio_tela_serial.sv
// Directed bench for envio_tela_serial: one instance at 4 cycles/bit, one at 434 cycles/bit.
module tb_envio_tela_serial;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        env4 = 1'b0;
    logic        env434 = 1'b0;
    logic [7:0]  tela = 8'h00;
    logic [15:0] dados = 16'h0000;

    logic       s4, fim4, ocp4;
    logic [2:0] db4;
    logic       s434, fim434, ocp434;
    logic [2:0] db434;

    int n_checks = 0;
    int n_fail = 0;

    logic       line_a [0:21709];
    logic       fim_a  [0:21709];
    logic       ocp_a  [0:21709];
    logic [2:0] est_a  [0:21709];

    envio_tela_serial #(.CICLOS_POR_BIT(4), .TERMINADOR(8'h0A)) dut4 (
        .clock(clock), .reset(reset), .envia_dados(env4),
        .tela_renderizada(tela), .dados(dados),
        .saida_serial(s4), .fim_envia_dados(fim4), .ocupado(ocp4), .db_estado(db4)
    );

    envio_tela_serial #(.CICLOS_POR_BIT(434), .TERMINADOR(8'h0A)) dut434 (
        .clock(clock), .reset(reset), .envia_dados(env434),
        .tela_renderizada(tela), .dados(dados),
        .saida_serial(s434), .fim_envia_dados(fim434), .ocupado(ocp434), .db_estado(db434)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a frame and records outputs for cycles 1..ncyc (cycle 1 = first cycle after the accepting edge).
    // If inj > 0, a competing request with other data is pulsed on dut4 during cycle inj.
    task automatic capture(input bit sel, input logic [7:0] t, input logic [15:0] d,
                           input int ncyc, input int inj);
        @(negedge clock);
        tela = t;
        dados = d;
        if (sel) env434 = 1'b1; else env4 = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            if (c == 1) begin
                env4 = 1'b0; env434 = 1'b0; tela = ~t; dados = ~d;
            end
            if (inj > 0 && c == inj) begin
                env4 = 1'b1; tela = 8'hF3; dados = 16'hFFFF;
            end
            if (inj > 0 && c == inj + 1) env4 = 1'b0;
            line_a[c] = sel ? s434 : s4;
            fim_a[c]  = sel ? fim434 : fim4;
            ocp_a[c]  = sel ? ocp434 : ocp4;
            est_a[c]  = sel ? db434 : db4;
        end
    endtask

    task automatic verify(input string nm, input int n, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        logic [7:0] eb [5];
        logic [7:0] got;
        logic       exp_bit;
        int mism, first_fim, n_fim, n_ocp, idx, k, p;
        eb[0] = e0; eb[1] = e1; eb[2] = e2; eb[3] = e3; eb[4] = e4;
        mism = 0;
        for (int c = 1; c <= 50 * n; c++) begin
            idx = (c - 1) / n;
            k = idx / 10;
            p = idx % 10;
            if (p == 0) exp_bit = 1'b0;
            else if (p == 9) exp_bit = 1'b1;
            else exp_bit = eb[k][p-1];
            if (line_a[c] !== exp_bit) mism++;
        end
        check_eq({nm, "_wave_mismatch_cycles"}, mism, 0);
        for (int b = 0; b < 5; b++) begin
            got = 8'h00;
            for (int i = 0; i < 8; i++) got[i] = line_a[b * 10 * n + (i + 1) * n + n / 2 + 1];
            check_eq($sformatf("%s_byte%0d", nm, b), {24'd0, got}, {24'd0, eb[b]});
        end
        first_fim = 0; n_fim = 0; n_ocp = 0;
        for (int c = 1; c <= 50 * n + 5; c++) begin
            if (fim_a[c] === 1'b1) begin
                n_fim++;
                if (first_fim == 0) first_fim = c;
            end
            if (c <= 50 * n + 1 && ocp_a[c] === 1'b1) n_ocp++;
        end
        check_eq({nm, "_fim_cycle"}, first_fim, 50 * n + 1);
        check_eq({nm, "_fim_count"}, n_fim, 1);
        check_eq({nm, "_ocupado_cycles"}, n_ocp, 50 * n + 1);
        check_eq({nm, "_ocupado_after"}, {31'd0, ocp_a[50 * n + 2]}, 0);
        check_eq({nm, "_estado_fim"}, {29'd0, est_a[50 * n + 1]}, 4);
        check_eq({nm, "_line_after"}, {31'd0, line_a[50 * n + 5]}, 1);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_saida", {31'd0, s4}, 1);
        check_eq("rst_fim", {31'd0, fim4}, 0);
        check_eq("rst_ocupado", {31'd0, ocp4}, 0);
        check_eq("rst_estado", {29'd0, db4}, 0);
        reset = 1'b0;

        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (s4 !== 1'b1 || fim4 !== 1'b0 || ocp4 !== 1'b0 || db4 !== 3'd0) bad++;
        end
        check_eq("idle_bad_cycles", bad, 0);

        capture(1'b0, 8'hF0, 16'h0000, 205, 0);
        check_eq("main_cycle1_low", {31'd0, line_a[1]}, 0);
        verify("main", 4, 8'hF0, 8'h00, 8'h00, 8'hF0, 8'h0A);

        capture(1'b0, 8'hF4, 16'h1234, 205, 0);
        verify("payload", 4, 8'hF4, 8'h12, 8'h34, 8'hD2, 8'h0A);

        capture(1'b0, 8'hF1, 16'h5678, 205, 60);
        verify("busy", 4, 8'hF1, 8'h56, 8'h78, 8'hDF, 8'h0A);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (s4 !== 1'b1 || fim4 !== 1'b0 || ocp4 !== 1'b0) bad++;
        end
        check_eq("busy_no_second_frame", bad, 0);

        capture(1'b0, 8'hF5, 16'hA55A, 89, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("midrst_saida", {31'd0, s4}, 1);
        check_eq("midrst_estado", {29'd0, db4}, 0);
        check_eq("midrst_ocupado", {31'd0, ocp4}, 0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (fim4 !== 1'b0) bad++;
        end
        reset = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clock);
            if (fim4 !== 1'b0 || s4 !== 1'b1 || db4 !== 3'd0) bad++;
        end
        check_eq("midrst_no_fim", bad, 0);
        capture(1'b0, 8'hF6, 16'h0102, 205, 0);
        verify("after_rst", 4, 8'hF6, 8'h01, 8'h02, 8'hF5, 8'h0A);

        capture(1'b1, 8'hF2, 16'h00FF, 21705, 0);
        verify("baud434", 434, 8'hF2, 8'h00, 8'hFF, 8'h0D, 8'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/envio_tela_serial.md
Name: envio_tela_serial

Overview:
- Transmitter stage directly downstream of the menu control unit.
- On an `envia_dados` pulse it captures the screen code `tela_renderizada` and a 16-bit data word (score or game data).
- It sends them to the Python renderer as a fixed 5-byte UART 8N1 frame.
- It then pulses `fim_envia_dados` back to the control unit, which is waiting in its `espera_envia_*` states.

Parameters:
- CICLOS_POR_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- TERMINADOR, 8'h0A, value of the last byte of every frame.

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- envia_dados  input  1  start request; sampled only in state OCIOSO
- tela_renderizada  input  8  screen code, captured at start
- dados  input  16  payload word, captured at start
- saida_serial  output  1  UART TX line; idle high
- fim_envia_dados  output  1  one-cycle pulse when the frame is complete
- ocupado  output  1  high from capture until the end of the FIM state
- db_estado  output  3  debug state code

Behaviour:
- Reset values (asynchronous, active-high):
  - saida_serial=1, fim_envia_dados=0, ocupado=0, db_estado=0.
  - State OCIOSO; all counters and shadow registers zero.
- All outputs are registered. No combinational path from any input to any output.
- Frame format, in send order:
  - B0 = tela
  - B1 = dados[15:8]
  - B2 = dados[7:0]
  - B3 = B0^B1^B2 (checksum)
  - B4 = TERMINADOR
- Byte format: start bit 0, then 8 data bits LSB first, then stop bit 1. Every bit lasts exactly CICLOS_POR_BIT cycles.
- Bytes are sent back-to-back: the stop bit of Bk is followed immediately by the start bit of Bk+1, with no idle gap.
- States (db_estado code):
  - OCIOSO(0): saida_serial=1, ocupado=0. If envia_dados=1 at an edge, that edge:
    - latches tela/dados into shadow registers and computes the checksum;
    - sets byte index=0, bit-cycle counter=0;
    - goes to START.
  - START(1): saida_serial=0 for CICLOS_POR_BIT cycles, then goes to DADOS with bit index=0.
  - DADOS(2): saida_serial=Bk[bit index], CICLOS_POR_BIT cycles per bit. After bit 7, goes to STOP.
  - STOP(3): saida_serial=1 for CICLOS_POR_BIT cycles. Then:
    - if byte index<4: increment it and go to START;
    - else: go to FIM.
  - FIM(4): fim_envia_dados=1 for exactly one cycle, saida_serial=1. Then goes to OCIOSO.
  - Any other state code goes to OCIOSO on the next edge, with saida_serial=1.
- Latency:
  - saida_serial falls in the first cycle after the edge that sampled envia_dados=1.
  - fim_envia_dados is high in cycle 50*CICLOS_POR_BIT+1, counted from that edge (cycle 1 = first START cycle).
- ocupado=1 in all states except OCIOSO.
- envia_dados is ignored outside OCIOSO. There is no queueing; a request made while busy is lost.
- envia_dados is level-sampled in OCIOSO. If it is still high in the cycle after FIM, a new frame starts with freshly captured inputs. The control unit drives single-cycle pulses.
- tela_renderizada and dados may change after capture with no effect on the frame in progress.
- Reset mid-frame:
  - saida_serial returns to 1 immediately (asynchronously);
  - the frame is abandoned and fim_envia_dados is not pulsed.
- Bit-cycle counter is 16 bits wide and compares against CICLOS_POR_BIT-1. Byte index is 3 bits; bit index is 3 bits.

Test Plan (CICLOS_POR_BIT=4 unless stated):
- Idle after reset: no requests for 100 cycles -> saida_serial=1, ocupado=0, fim_envia_dados=0, db_estado=0 throughout.
- Main menu frame: tela=8'hF0, dados=16'h0000, one-cycle envia_dados.
  - Decoded bytes must be F0 00 00 F0 0A.
  - saida_serial low in cycle 1; fim_envia_dados high only in cycle 201.
  - ocupado high in cycles 1-201.
- Payload and checksum: tela=8'hF4, dados=16'h1234.
  - Decoded bytes must be F4 12 34 D2 0A, LSB first.
  - Every bit lasts 4 cycles; no gaps between bytes.
- Busy rejection: start a frame with tela=8'hF1, then pulse envia_dados with tela=8'hF3 at cycle 60.
  - Exactly one frame, F1 .. ..; exactly one fim_envia_dados pulse.
  - Changing dados mid-frame does not alter the bytes.
- Reset mid-frame: assert reset at cycle 90 of a frame.
  - saida_serial=1 in the same cycle; no fim pulse; db_estado=0.
  - A new request after release sends a complete, correct frame.
- Baud parameter: CICLOS_POR_BIT=434, tela=8'hF2, dados=16'h00FF.
  - Bytes F2 00 FF 0D 0A.
  - fim_envia_dados in cycle 21701.
